// File: rtl/reorder_buffer.sv
// Reorder buffer: tracks in-flight instructions in a circular buffer and retires them in issue order; tag = slot + 1, tag 0 = no producer.
// Latency: issue and CDB writes land at the next edge; a ready head entry is committed with registered rf_modify* one edge later.
// Backpressure: issue_ready drops when full (a same-cycle commit does not reopen it); rdy_in=0 freezes all state. Macro ROB_QUERY_EN enables operand lookup.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             issue_has_rd,
  output logic             issue_ready,
  output logic [TAG_W-1:0] issue_entry,
  output logic             rf_reorder,
  output logic [TAG_W-1:0] rf_reorder_entry,
  output logic [4:0]       rf_reorder_rd,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_entry,
  input  logic [31:0]      cdb_value,
  input  logic             flush_in,
  output logic             rf_modify,
  output logic [TAG_W-1:0] rf_modify_entry,
  output logic [4:0]       rf_modify_index,
  output logic [31:0]      rf_modify_value,
  input  logic [TAG_W-1:0] q1_entry,
  input  logic [TAG_W-1:0] q2_entry,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_value,
  output logic [31:0]      q2_value
);
  localparam int IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        has_rd;
    logic [4:0]  rd;
    logic [31:0] value;
  } rob_entry_t;

  rob_entry_t       entries [ROB_SIZE];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             commit;
  logic             cdb_hit;
  logic [IDX_W-1:0] cdb_idx;
  rob_entry_t       head_ent;

  // Issue side: full check uses the registered count only, so a commit in
  // the same cycle never lets a full buffer accept.
  assign issue_ready      = (count != CNT_W'(ROB_SIZE));
  assign issue_entry      = TAG_W'(tail) + TAG_W'(1);
  assign accept           = issue_valid && issue_ready && rdy_in && !flush_in;
  assign rf_reorder       = accept && issue_has_rd && (issue_rd != 5'd0);
  assign rf_reorder_entry = issue_entry;
  assign rf_reorder_rd    = issue_rd;

  // Broadcasts to tag 0, out-of-range tags or idle slots are dropped.
  assign cdb_idx  = IDX_W'(cdb_entry - TAG_W'(1));
  assign cdb_hit  = cdb_valid && (cdb_entry != '0) && (cdb_entry <= TAG_W'(ROB_SIZE))
                    && entries[cdb_idx].busy;

  // Commit looks at the registered ready bit, so a CDB write is retired one edge later at the earliest.
  assign head_ent = entries[head];
  assign commit   = head_ent.busy && head_ent.ready;

  // Entry array, pointers, occupancy and the registered commit port.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      rf_modify       <= 1'b0;
      rf_modify_entry <= '0;
      rf_modify_index <= '0;
      rf_modify_value <= '0;
    end else if (!rdy_in) begin
      rf_modify <= 1'b0;
    end else if (flush_in) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries[i].busy  <= 1'b0;
        entries[i].ready <= 1'b0;
      end
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rf_modify <= 1'b0;
    end else begin
      rf_modify <= 1'b0;
      if (cdb_hit) begin
        entries[cdb_idx].value <= cdb_value;
        entries[cdb_idx].ready <= 1'b1;
      end
      // Placed after the CDB write so retiring the head wins on the same slot.
      if (commit) begin
        entries[head].busy  <= 1'b0;
        entries[head].ready <= 1'b0;
        head                <= head + IDX_W'(1);
        rf_modify           <= head_ent.has_rd && (head_ent.rd != 5'd0);
        rf_modify_entry     <= TAG_W'(head) + TAG_W'(1);
        rf_modify_index     <= head_ent.rd;
        rf_modify_value     <= head_ent.value;
      end
      if (accept) begin
        entries[tail].busy   <= 1'b1;
        entries[tail].ready  <= 1'b0;
        entries[tail].has_rd <= issue_has_rd;
        entries[tail].rd     <= issue_rd;
        entries[tail].value  <= '0;
        tail                 <= tail + IDX_W'(1);
      end
      case ({accept, commit})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ROB_QUERY_EN
  logic [TAG_W-1:0] q_entry [2];
  logic [IDX_W-1:0] q_idx   [2];
  logic             q_rdy   [2];
  logic [31:0]      q_val   [2];

  assign q_entry[0] = q1_entry;
  assign q_entry[1] = q2_entry;
  assign q_idx[0]   = IDX_W'(q1_entry - TAG_W'(1));
  assign q_idx[1]   = IDX_W'(q2_entry - TAG_W'(1));

  // Operand lookup: a same-cycle broadcast to the queried tag bypasses the array.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      q_rdy[i] = 1'b0;
      q_val[i] = '0;
      if ((q_entry[i] != '0) && (q_entry[i] <= TAG_W'(ROB_SIZE)) && entries[q_idx[i]].busy) begin
        if (cdb_valid && (cdb_entry == q_entry[i])) begin
          q_rdy[i] = 1'b1;
          q_val[i] = cdb_value;
        end else if (entries[q_idx[i]].ready) begin
          q_rdy[i] = 1'b1;
          q_val[i] = entries[q_idx[i]].value;
        end
      end
    end
  end

  assign q1_ready = q_rdy[0];
  assign q1_value = q_val[0];
  assign q2_ready = q_rdy[1];
  assign q2_value = q_val[1];
`else
  logic unused_query;
  assign unused_query = ^{q1_entry, q2_entry};
  assign q1_ready     = 1'b0;
  assign q2_ready     = 1'b0;
  assign q1_value     = '0;
  assign q2_value     = '0;
`endif

endmodule
